// File: rtl/bcd_gray_arbiter.sv
// Round-robin arbiter sharing one BCD-to-Gray converter between NREQ requesters.
// The converted digit is held, tagged with its requester, in a one-entry output register.
module bcd_gray_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_bcd,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_gray,
    output logic [3:0]        out_bcd,
    output logic [IDW-1:0]    out_id,
    output logic              out_err,
    output logic [15:0]       conv_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] ptr_next;
    logic [IDW:0]   scan;
    logic           found;
    logic           can_accept;
    logic           accept;
    logic [3:0]     bcd_arr [NREQ];
    logic [3:0]     sel_bcd;
    logic [3:0]     sel_gray;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign bcd_arr[gi] = req_bcd[4*gi +: 4];
    end

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                grant = scan[IDW-1:0];
            end
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high. req_ready goes only to the grantee, and only when the output register
    // is empty or is being drained in the same cycle; it is held low during reset.
    assign can_accept = rst_n && ((state == EMPTY) || out_ready);
    assign accept     = found && can_accept;
    assign sel_bcd    = bcd_arr[grant];
    assign sel_gray   = {sel_bcd[3], sel_bcd[3] ^ sel_bcd[2],
                         sel_bcd[2] ^ sel_bcd[1], sel_bcd[1] ^ sel_bcd[0]};
    assign ptr_next   = (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
    assign out_valid  = (state == FULL);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            out_gray   <= '0;
            out_bcd    <= '0;
            out_id     <= '0;
            out_err    <= 1'b0;
            conv_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                out_gray   <= sel_gray;
                out_bcd    <= sel_bcd;
                out_id     <= grant;
                out_err    <= (sel_bcd > 4'd9);
                ptr        <= ptr_next;
                conv_count <= conv_count + 16'd1;
            end
        end
    end

endmodule
